// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the single-cycle MIPS core.
// Packs accepted bytes into little-endian 32-bit words (byte 0 -> bits 7:0)
// and writes them sequentially into instruction memory from BASE_ADDR upward.
// Holds the CPU in reset until the last word is committed.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a running XOR of all payload bytes is kept. After the final
//   word, one checksum byte is accepted; a mismatch ends in the error state.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   in_valid    source presents a byte on in_data
//   in_data     payload byte
//   in_last     marks the final payload byte (only meaningful when accepted)
//   in_ready    loader accepts the byte this cycle
//   imem_we     instruction-memory write strobe, one cycle per word
//   imem_addr   byte address of the word being written
//   imem_wdata  packed word
//   cpu_hold    high keeps the core in reset
//   load_done   sticky, program fully written
//   word_count  number of words committed (saturates at DEPTH_WORDS)
//   error       sticky, overflow (or checksum mismatch when enabled)
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned CNT_WIDTH   = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 imem_we,
  output logic [31:0]          imem_addr,
  output logic [31:0]          imem_wdata,
  output logic                 cpu_hold,
  output logic                 load_done,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic                 error
);

  typedef enum logic [2:0] {
    COLLECT,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERR
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH_WORDS);

  state_t     state;
  logic [1:0] idx;
  logic       last_seen;
  logic       accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= COLLECT;
      idx        <= '0;
      last_seen  <= 1'b0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      word_count <= '0;
      error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      case (state)
        COLLECT: begin
          // in_ready is registered, so it rises one cycle after the first
          // non-reset edge and is re-armed on every return to COLLECT.
          in_ready <= 1'b1;
          if (accept) begin
            if (word_count == DEPTH_CNT) begin
              // Memory already full: the byte is dropped and loading stops.
              state    <= ERR;
              error    <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              imem_wdata[8*idx +: 8] <= in_data;
              idx <= idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum <= csum ^ in_data;
`endif
              if (idx == 2'd3 || in_last) begin
                state     <= WRITE;
                in_ready  <= 1'b0;
                imem_we   <= 1'b1;
                imem_addr <= BASE_ADDR + (32'(word_count) << 2);
                last_seen <= in_last;
              end
            end
          end
        end

        WRITE: begin
          imem_we    <= 1'b0;
          idx        <= '0;
          // Cleared so a short final word carries zero upper bytes.
          imem_wdata <= '0;
          if (word_count != DEPTH_CNT) word_count <= word_count + 1'b1;
          if (last_seen) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state    <= CHECK;
            in_ready <= 1'b1;
`else
            state     <= DONE;
            cpu_hold  <= 1'b0;
            load_done <= 1'b1;
`endif
          end else begin
            state    <= COLLECT;
            in_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state     <= DONE;
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif

        DONE: begin
          in_ready <= 1'b0;
          imem_we  <= 1'b0;
        end

        ERR: begin
          in_ready <= 1'b0;
          imem_we  <= 1'b0;
        end

        default: begin
          state    <= ERR;
          error    <= 1'b1;
          in_ready <= 1'b0;
          imem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random byte streams with random
// valid gaps, checked against a word-level packing model of the load.
module tb_imem_loader;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          DEPTH = 4;
  localparam int          CW    = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic [CW-1:0] word_count;
  logic          error;

  imem_loader #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .word_count(word_count),
    .error     (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_we_cyc = -1;
  int done_cyc = -1;

  logic [7:0]  stim[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write observer: records every strobed word and the completion cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      last_we_cyc = cyc;
      chk("ready_in_write", {31'd0, in_ready}, 32'd0);
    end
    if (load_done && done_cyc < 0) done_cyc = cyc;
  end

  // Caller is at a negedge; one reset edge is applied and checked.
  task automatic apply_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    last_we_cyc = -1;
    done_cyc = -1;
  endtask

  // gap < 0: valid offered on alternate cycles; else gap is % idle chance.
  // A byte once offered is held until accepted.
  task automatic send(input logic [7:0] q[$], input bit with_last, input int gap);
    int  i = 0;
    int  budget = 0;
    bit  pend = 1'b0;
    int  n = q.size();
    while (i < n && budget < 400) begin
      @(negedge clk);
      budget++;
      if (!pend) begin
        if ((gap < 0) ? (budget % 2 == 0) : ($urandom_range(99) < gap)) begin
          in_valid = 1'b0;
          in_last  = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_data  = q[i];
          in_last  = with_last && (i == n - 1);
        end
      end
      if (in_valid && in_ready) begin
        i++;
        pend = 1'b0;
      end else begin
        pend = in_valid;
      end
    end
    if (i != n) chk("send_timeout", i, n);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  function automatic logic [31:0] pack_word(input int w);
    logic [31:0] v = '0;
    for (int k = 0; k < 4; k++)
      if (4 * w + k < stim.size()) v |= 32'(stim[4 * w + k]) << (8 * k);
    return v;
  endfunction

  function automatic logic [7:0] xor_all();
    logic [7:0] x = '0;
    foreach (stim[j]) x ^= stim[j];
    return x;
  endfunction

  task automatic fill_random(input int n);
    stim.delete();
    for (int j = 0; j < n; j++) stim.push_back(8'($urandom));
  endtask

  // Streams stim, then (checksum build) a checksum byte, and checks results.
  task automatic run_load(input bit with_last, input int gap, input bit cks_good);
    int n = stim.size();
    bit ovf = (n > 4 * DEPTH);
    int nw = ovf ? DEPTH : (n + 3) / 4;
    bit exp_done;
    bit exp_err;
    logic [7:0] cq[$];
    send(stim, with_last, gap);
    exp_done = with_last && !ovf;
    exp_err  = ovf;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (with_last && !ovf) begin
      cq.push_back(cks_good ? xor_all() : (xor_all() ^ 8'h01));
      send(cq, 1'b0, gap);
      exp_done = cks_good;
      exp_err  = !cks_good;
    end
`else
    cq.delete();
    if (!cks_good) exp_done = 1'b0;
`endif
    for (int k = 0; k < 40 && !(load_done || error); k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("n_writes", wr_addr.size(), nw);
    for (int w = 0; w < nw && w < wr_addr.size(); w++) begin
      chk("wr_addr", wr_addr[w], BASE + 32'(4 * w));
      chk("wr_data", wr_data[w], pack_word(w));
    end
    chk("word_count", 32'(word_count), nw);
    chk("load_done", {31'd0, load_done}, {31'd0, exp_done});
    chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, !exp_done});
    chk("error", {31'd0, error}, {31'd0, exp_err});
    chk("idle_ready", {31'd0, in_ready}, 32'd0);
    chk("idle_we", {31'd0, imem_we}, 32'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (exp_done) chk("done_latency", done_cyc - last_we_cyc, 32'd1);
`endif
  endtask

  initial begin
    @(negedge clk);
    apply_reset();

    // Eight sequential bytes, continuous valid.
    stim.delete();
    for (int j = 1; j <= 8; j++) stim.push_back(8'(j));
    run_load(1'b1, 0, 1'b1);

    // Six bytes, valid toggling.
    apply_reset();
    stim.delete();
    for (int j = 1; j <= 6; j++) stim.push_back(8'(j));
    run_load(1'b1, -1, 1'b1);

    // Single byte word.
    apply_reset();
    stim.delete();
    stim.push_back(8'hFF);
    run_load(1'b1, 0, 1'b1);

    // Overflow: one byte beyond capacity, never flagged last.
    apply_reset();
    fill_random(4 * DEPTH + 1);
    run_load(1'b0, 20, 1'b1);

    // Reset landing on a WRITE cycle.
    apply_reset();
    fill_random(4);
    send(stim, 1'b0, 0);
    chk("we_before_reset", {31'd0, imem_we}, 32'd1);
    apply_reset();

    // Reset mid second word, then reload from BASE.
    fill_random(6);
    send(stim, 1'b0, 0);
    chk("count_before_reset", 32'(word_count), 32'd1);
    apply_reset();
    fill_random(4);
    run_load(1'b1, 30, 1'b1);

    // Random loads.
    for (int t = 0; t < 10; t++) begin
      apply_reset();
      fill_random($urandom_range(1, 4 * DEPTH));
      run_load(1'b1, $urandom_range(0, 60), 1'b1);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    apply_reset();
    stim.delete();
    stim.push_back(8'h11); stim.push_back(8'h22);
    stim.push_back(8'h33); stim.push_back(8'h44);
    run_load(1'b1, 0, 1'b1);
    apply_reset();
    run_load(1'b1, 0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Hardware program loader for the single-cycle MIPS core.
- Accepts a byte stream over a valid/ready handshake, packs it into little-endian 32-bit words and writes them sequentially into instruction memory.
- Byte order matches data memory: byte 0 is bits 7:0.
- Holds the CPU in reset (cpu_hold) until the final word is committed, then releases it. It is the write-side counterpart of the simulation observer that reads PC, registers and memory.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written.
- DEPTH_WORDS, 256, capacity of instruction memory in words. Also the overflow limit.
- CNT_WIDTH, 9, width of word_count. Must hold DEPTH_WORDS.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  8  payload byte.
- in_last  input  1  qualifies the final payload byte.
- in_ready  output  1  loader accepts the byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  32  byte address of the word being written.
- imem_wdata  output  32  packed word.
- cpu_hold  output  1  high keeps the core in reset.
- load_done  output  1  sticky; program fully written.
- word_count  output  CNT_WIDTH  number of words committed.
- error  output  1  sticky; overflow, or checksum failure when the optional feature is enabled.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port name reset; it is sampled only on the rising edge of clk.
- Reset values:
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_hold=1, load_done=0, word_count=0, error=0.
  - Byte index=0, state=COLLECT.
- States: COLLECT, WRITE, CHECK (only with the optional feature), DONE, ERR.
- COLLECT:
  - in_ready=1, starting the first cycle after reset deasserts.
  - A transfer occurs when in_valid and in_ready are both 1.
  - The accepted byte goes to imem_wdata[8*idx+7:8*idx]; idx then increments.
  - idx==3, or in_last=1, moves the FSM to WRITE next cycle.
  - If in_last arrives with idx<3, the unfilled upper bytes are zero (e.g. 2 bytes AA,BB give 0000BBAA).
- WRITE (exactly 1 cycle):
  - in_ready=0.
  - imem_we=1, imem_addr=BASE_ADDR+4*word_count, imem_wdata holds the packed word.
  - word_count increments at the end of the cycle; idx and the word register clear.
  - Next state: DONE (or CHECK) if the last byte was flagged, else COLLECT.
- Overflow: a byte is accepted in COLLECT while word_count==DEPTH_WORDS.
  - The FSM goes to ERR: error=1, no write, in_ready=0, cpu_hold stays 1.
  - ERR is left only by reset.
- DONE:
  - cpu_hold=0, load_done=1, in_ready=0, imem_we=0.
  - Outputs stable until reset.
- Handshake:
  - in_valid while in_ready=0 is ignored; the source must hold its data.
  - in_last is meaningful only on an accepted byte.
- Throughput: 4 bytes take 4 cycles, plus 1 WRITE cycle. Worst case is 5 cycles per word.
- Reset mid-operation:
  - Any partial word is discarded; all outputs return to their reset values.
  - Words already written to memory are not cleared.
  - Reset during WRITE: imem_we is deasserted on the same edge (synchronous reset has priority).
- word_count saturates at DEPTH_WORDS and never wraps.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all accepted payload bytes is kept.
  - After the final WRITE, the FSM enters CHECK with in_ready=1 and accepts exactly one checksum byte (in_last ignored).
  - Match: go to DONE.
  - Mismatch: go to ERR (error=1, cpu_hold=1, load_done=0).
- Undefined:
  - No CHECK state; the FSM goes WRITE to DONE directly.
  - error is set only by overflow.

Test Plan:
- 8 bytes 01..08 back-to-back, last on 08 -> 2 imem_we pulses.
  - addr 0x0 data 0x04030201; addr 0x4 data 0x08070605.
  - word_count=2, load_done=1, cpu_hold=0 one cycle after the second write.
- 6 bytes with in_valid toggling every other cycle, last on 6th -> 2nd word 0x00000605 at 0x4.
  - No byte lost or duplicated.
  - in_ready=0 during each WRITE cycle.
- DEPTH_WORDS=2, 9 bytes with no last -> 2 writes, then error=1 on the 9th byte.
  - cpu_hold stays 1, no third imem_we.
- Reset asserted after 2 bytes of the second word -> next cycle all outputs at reset values.
  - A reload of 4 bytes writes to BASE_ADDR.
- With IMEM_LOADER_CHECKSUM_EN, bytes 11 22 33 44 (last), then checksum 44 -> load_done=1.
  - Repeat with checksum 45 -> error=1, cpu_hold=1.
- BASE_ADDR=0x100, single byte FF with last -> write addr 0x100, data 0x000000FF, word_count=1.
